display_blinker: RTL and testbench
==================================

# display_blinker

Parametrised multi-digit display blinker for the alarm-clock display path. Registers a packed vector of digit codes and, per digit selected by a blink mask, substitutes a blank code during alternate half-periods of a programmable blink timebase. Generalises the single-digit, fixed-rate, single-flag blinker: N digits, per-digit enables, programmable rate, restart control and a phase status output. Sits between the time/alarm formatting logic and the seven-segment decoders.

## Interface
- DIGITS, 4, number of display digits (1..8)
- DW, 4, width of one digit code
- DIV_W, 8, width of the half-period divider
- BLANK_CODE, 4'hF (DW bits), code driven on a blanked digit; the decoder renders it dark

- clk_100hz  in  1  display clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- disp  in  DIGITS*DW  digit codes; digit i at [i*DW +: DW]
- blink_en  in  DIGITS  per-digit blink enable; bit i controls digit i
- half_period  in  DIV_W  half-period length in clocks; 0 treated as 1
- restart  in  1  single-cycle pulse; restarts the timebase in the visible phase
- out  out  DIGITS*DW  registered digit codes to the decoders
- blank_phase  out  1  1 while the timebase is in the blanking half-period

## Operation
- Timebase: counter cnt (DIV_W bits) and phase bit ph; blank_phase = ph.
- Effective half-period hp = (half_period == 0) ? 1 : half_period.
- Active when |blink_en = 1: if cnt >= hp-1, cnt <= 0 and ph <= ~ph; else cnt <= cnt+1. Full period = 2*hp clocks.
- Idle when blink_en == 0: cnt <= 0, ph <= 0. The first blanked half-period starts hp clocks after blink_en becomes nonzero.
- restart = 1 overrides everything else: cnt <= 0, ph <= 0.
- Output per digit i, registered: out[i] <= (blink_en[i] & ph_next) ? BLANK_CODE : disp[i], where ph_next is the phase value written in the same cycle. out and blank_phase always agree.
- half_period lowered mid-count so that cnt >= new hp-1: the phase toggles on the next edge; no counter wrap-through.
- blink_en bits change mid-period: takes effect on the next edge without disturbing the timebase, as long as at least one bit stays set.
- disp equal to BLANK_CODE is passed through unchanged.

## Timing
- Reset (async assert, sync-safe deassert by the system): out = 0, cnt = 0, ph = 0, blank_phase = 0.
- disp to out latency: 1 clock.
- blink_en to out latency: 1 clock.
- restart asserted in cycle t: at edge t+1, out shows disp and blank_phase = 0; the first blank edge is at t+1+hp.
- hp = 1: phase toggles every clock, matching the legacy 50 Hz blink at 100 Hz.
- Reset mid-period: timebase and out clear immediately; no partial-period carry-over.

## Configuration
- BLINK_EDGE_RESYNC_EN defined: register blink_en. Any 0->1 transition on any bit (blink_en & ~blink_en_q != 0) forces cnt <= 0, ph <= 1. The newly enabled digit blanks on the next edge for immediate user feedback. restart still has priority.
- BLINK_EDGE_RESYNC_EN undefined: no edge register and no resync. Newly enabled digits follow the running timebase.

## Structure
- Shared package display_pkg:
  - DEFAULT_BLANK_CODE (4'hF)
  - DEFAULT_DIGITS
  - function hp_eff(half_period) implementing the zero-as-one rule
- Sub-module blink_timebase: cnt/ph counter with inputs active, hp, restart, and optionally resync.
- Top level holds the per-digit output mux and registers, plus the BLINK_EDGE_RESYNC_EN logic.

## Test plan
- Reset, then disp=16'h1234, blink_en=0 -> out=16'h1234 one clock later; blank_phase stays 0 indefinitely.
- half_period=3, blink_en=4'b0011, disp=16'h1234 -> out alternates 16'h1234 (3 clks) / 16'h12FF (3 clks), starting visible.
- half_period=0, blink_en=4'b1000 -> out toggles each clock between 16'h1234 and 16'hF234.
- Mid blank phase (half_period=5), pulse restart -> next edge out=16'h1234, blank_phase=0, next blank edge exactly 5 clocks later.
- During count with cnt=6 at half_period=10, change half_period to 4 -> phase toggles on the next edge; rst_n pulsed low mid-period -> out=0 immediately.
- With BLINK_EDGE_RESYNC_EN: blink_en 0->4'b0100 in visible phase -> next edge out digit 2 = F, blank_phase=1, cnt=0; without the macro, digit 2 waits for the timebase.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared constants and helpers for the display blinker path.
`default_nettype none

package display_pkg;

    localparam int          DEFAULT_DIGITS     = 4;
    localparam logic [3:0]  DEFAULT_BLANK_CODE = 4'hF;
    localparam int          HP_MAX_W           = 16;

    // A programmed half-period of zero is treated as one clock.
    function automatic logic [HP_MAX_W-1:0] hp_eff(input logic [HP_MAX_W-1:0] half_period);
        return (half_period == '0) ? HP_MAX_W'(1) : half_period;
    endfunction

endpackage

`default_nettype wire

// File: rtl/blink_timebase.sv
// blink_timebase: half-period counter and phase bit; exposes next-phase for output alignment.
`default_nettype none

module blink_timebase
    import display_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_100hz,
    input  logic             rst_n,
    input  logic             active,
    input  logic [DIV_W-1:0] half_period,
    input  logic             restart,
    input  logic             resync,
    output logic             ph,
    output logic             ph_next
);

    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    cnt_next;
    logic [HP_MAX_W-1:0] hp;
    logic                at_end;

    assign hp     = hp_eff(HP_MAX_W'(half_period));
    // >= rather than == so a lowered half-period toggles at once instead of wrapping.
    assign at_end = (HP_MAX_W'(cnt) >= (hp - HP_MAX_W'(1)));

    always_comb begin
        cnt_next = cnt;
        ph_next  = ph;
        if (restart) begin
            cnt_next = '0;
            ph_next  = 1'b0;
        end else if (resync) begin
            cnt_next = '0;
            ph_next  = 1'b1;
        end else if (!active) begin
            cnt_next = '0;
            ph_next  = 1'b0;
        end else if (at_end) begin
            cnt_next = '0;
            ph_next  = ~ph;
        end else begin
            cnt_next = cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_100hz or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ph  <= 1'b0;
        end else begin
            cnt <= cnt_next;
            ph  <= ph_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_blinker.sv
// display_blinker: per-digit blanking of a registered digit vector on a programmable timebase.
// Optional feature macro: BLINK_EDGE_RESYNC_EN (newly enabled digits blank immediately).
`default_nettype none

module display_blinker
    import display_pkg::*;
#(
    parameter int             DIGITS     = DEFAULT_DIGITS,
    parameter int             DW         = 4,
    parameter int             DIV_W      = 8,
    parameter logic [DW-1:0]  BLANK_CODE = DW'(DEFAULT_BLANK_CODE)
) (
    input  logic                   clk_100hz,
    input  logic                   rst_n,
    input  logic [DIGITS*DW-1:0]   disp,
    input  logic [DIGITS-1:0]      blink_en,
    input  logic [DIV_W-1:0]       half_period,
    input  logic                   restart,
    output logic [DIGITS*DW-1:0]   out,
    output logic                   blank_phase
);

    logic ph;
    logic ph_next;
    logic resync;

`ifdef BLINK_EDGE_RESYNC_EN
    logic [DIGITS-1:0] blink_en_q;

    always_ff @(posedge clk_100hz or negedge rst_n) begin
        if (!rst_n) begin
            blink_en_q <= '0;
        end else begin
            blink_en_q <= blink_en;
        end
    end

    assign resync = |(blink_en & ~blink_en_q);
`else
    assign resync = 1'b0;
`endif

    blink_timebase #(
        .DIV_W (DIV_W)
    ) u_timebase (
        .clk_100hz   (clk_100hz),
        .rst_n       (rst_n),
        .active      (|blink_en),
        .half_period (half_period),
        .restart     (restart),
        .resync      (resync),
        .ph          (ph),
        .ph_next     (ph_next)
    );

    assign blank_phase = ph;

    // Muxing on ph_next keeps each registered digit aligned with blank_phase.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        always_ff @(posedge clk_100hz or negedge rst_n) begin
            if (!rst_n) begin
                out[i*DW +: DW] <= '0;
            end else begin
                out[i*DW +: DW] <= (blink_en[i] && ph_next) ? BLANK_CODE : disp[i*DW +: DW];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_blinker.sv
// tb_display_blinker: table-driven directed checks of display_blinker with default parameters.
`default_nettype none

module tb_display_blinker;

    logic        clk_100hz;
    logic        rst_n;
    logic [15:0] disp;
    logic [3:0]  blink_en;
    logic [7:0]  half_period;
    logic        restart;
    logic [15:0] out;
    logic        blank_phase;

    int n_vec;
    int n_bad;

    typedef struct {
        string       name;
        logic [15:0] disp;
        logic [3:0]  en;
        logic [7:0]  hp;
        logic        restart;
        logic [15:0] exp_out;
        logic        exp_bp;
    } vec_t;

    vec_t vecs[$];

    display_blinker dut (
        .clk_100hz   (clk_100hz),
        .rst_n       (rst_n),
        .disp        (disp),
        .blink_en    (blink_en),
        .half_period (half_period),
        .restart     (restart),
        .out         (out),
        .blank_phase (blank_phase)
    );

    initial clk_100hz = 1'b0;
    always #5 clk_100hz = ~clk_100hz;

    function automatic void add(string name, logic [15:0] d, logic [3:0] en, logic [7:0] hp,
                                logic rs, logic [15:0] eo, logic eb);
        vec_t v;
        v.name = name; v.disp = d; v.en = en; v.hp = hp; v.restart = rs;
        v.exp_out = eo; v.exp_bp = eb;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [15:0] eo, logic eb);
        n_vec++;
        if (out !== eo || blank_phase !== eb) begin
            n_bad++;
            $display("FAIL %s: out=%h blank_phase=%b, expected out=%h blank_phase=%b",
                     name, out, blank_phase, eo, eb);
        end
    endtask

    task automatic step();
        @(posedge clk_100hz);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0; disp = 16'h0; blink_en = 4'h0; half_period = 8'd0; restart = 1'b0;

        // Idle: output follows disp, no blanking.
        add("idle0", 16'h1234, 4'b0000, 8'd3, 1'b0, 16'h1234, 1'b0);
        add("idle1", 16'h1234, 4'b0000, 8'd3, 1'b0, 16'h1234, 1'b0);
        add("idle2", 16'h1234, 4'b0000, 8'd3, 1'b0, 16'h1234, 1'b0);
        // hp=3, two low digits blinking.
        add("hp3_v0", 16'h1234, 4'b0011, 8'd3, 1'b0, 16'h1234, 1'b0);
        add("hp3_v1", 16'h1234, 4'b0011, 8'd3, 1'b0, 16'h1234, 1'b0);
        add("hp3_b0", 16'h1234, 4'b0011, 8'd3, 1'b0, 16'h12FF, 1'b1);
        add("hp3_b1", 16'h1234, 4'b0011, 8'd3, 1'b0, 16'h12FF, 1'b1);
        add("hp3_b2", 16'h1234, 4'b0011, 8'd3, 1'b0, 16'h12FF, 1'b1);
        add("hp3_v2", 16'h1234, 4'b0011, 8'd3, 1'b0, 16'h1234, 1'b0);
        add("hp3_v3", 16'h1234, 4'b0011, 8'd3, 1'b0, 16'h1234, 1'b0);
        add("hp3_v4", 16'h1234, 4'b0011, 8'd3, 1'b0, 16'h1234, 1'b0);
        add("hp3_b3", 16'h1234, 4'b0011, 8'd3, 1'b0, 16'h12FF, 1'b1);
        // hp=0 behaves as 1: toggles every clock.
        add("hp0_0", 16'h1234, 4'b1000, 8'd0, 1'b0, 16'h1234, 1'b0);
        add("hp0_1", 16'h1234, 4'b1000, 8'd0, 1'b0, 16'hF234, 1'b1);
        add("hp0_2", 16'h1234, 4'b1000, 8'd0, 1'b0, 16'h1234, 1'b0);
        add("hp0_3", 16'h1234, 4'b1000, 8'd0, 1'b0, 16'hF234, 1'b1);
        // hp=5, restart in blank phase, next blank 5 clocks after.
        add("hp5_b0", 16'h1234, 4'b0011, 8'd5, 1'b0, 16'h12FF, 1'b1);
        add("hp5_b1", 16'h1234, 4'b0011, 8'd5, 1'b0, 16'h12FF, 1'b1);
        add("restart", 16'h1234, 4'b0011, 8'd5, 1'b1, 16'h1234, 1'b0);
        add("rs_v1", 16'h1234, 4'b0011, 8'd5, 1'b0, 16'h1234, 1'b0);
        add("rs_v2", 16'h1234, 4'b0011, 8'd5, 1'b0, 16'h1234, 1'b0);
        add("rs_v3", 16'h1234, 4'b0011, 8'd5, 1'b0, 16'h1234, 1'b0);
        add("rs_v4", 16'h1234, 4'b0011, 8'd5, 1'b0, 16'h1234, 1'b0);
        add("rs_blank", 16'h1234, 4'b0011, 8'd5, 1'b0, 16'h12FF, 1'b1);
        // hp=10 counting to cnt=6, then hp lowered to 4.
        for (int i = 1; i <= 6; i++)
            add($sformatf("hp10_c%0d", i), 16'h1234, 4'b0011, 8'd10, 1'b0, 16'h12FF, 1'b1);
        add("hp_lower", 16'h1234, 4'b0011, 8'd4, 1'b0, 16'h1234, 1'b0);
        add("hp4_c1", 16'h1234, 4'b0011, 8'd4, 1'b0, 16'h1234, 1'b0);
        // Enable mask narrowed mid-period: timebase undisturbed.
        add("en_chg0", 16'h1234, 4'b0001, 8'd4, 1'b0, 16'h1234, 1'b0);
        add("en_chg1", 16'h1234, 4'b0001, 8'd4, 1'b0, 16'h1234, 1'b0);
        add("en_chg_b", 16'h1234, 4'b0001, 8'd4, 1'b0, 16'h123F, 1'b1);
        // BLANK_CODE in disp passes through; new disp visible after one clock.
        add("pass_F", 16'hFFFF, 4'b0000, 8'd1, 1'b0, 16'hFFFF, 1'b0);
        add("disp_lat", 16'hF0F0, 4'b0000, 8'd1, 1'b0, 16'hF0F0, 1'b0);
        add("idle_ret", 16'h1234, 4'b0000, 8'd5, 1'b0, 16'h1234, 1'b0);

        repeat (3) @(posedge clk_100hz);
        #1;
        check("reset", 16'h0000, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            disp        = vecs[k].disp;
            blink_en    = vecs[k].en;
            half_period = vecs[k].hp;
            restart     = vecs[k].restart;
            step();
            check(vecs[k].name, vecs[k].exp_out, vecs[k].exp_bp);
        end

        // Newly enabled digit from idle, visible phase.
        blink_en = 4'b0100; disp = 16'h1234; half_period = 8'd5; restart = 1'b0;
        step();
`ifdef BLINK_EDGE_RESYNC_EN
        check("resync_edge", 16'h1F34, 1'b1);
        step();
        check("resync_hold", 16'h1F34, 1'b1);
`else
        check("no_resync", 16'h1234, 1'b0);
        step();
        check("no_resync2", 16'h1234, 1'b0);
`endif

        // Asynchronous reset mid-period clears without a clock edge.
        blink_en = 4'b1111; half_period = 8'd1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 16'h0000, 1'b0);
        step();
        rst_n = 1'b1;
        blink_en = 4'b0000; disp = 16'h5678;
        step();
        check("post_rst", 16'h5678, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
